// File: rtl/display_arbiter.sv
// display_arbiter
//   Shares one seven-segment display between NUM_CLIENTS requesters.
//   Arbitration is round-robin, starting from the client after the last
//   grant. A new owner keeps the display for at least MIN_HOLD cycles.
//   While the owner keeps its request high, data/pointEnable follow the
//   owner's inputs with one cycle of latency. After the owner drops its
//   request, they hold their last values.
//
//   Build option: DISPLAY_ARBITER_PREEMPT_EN
//     When this macro is defined, an owner that has held the grant for
//     TIMEOUT_CYCLES loses it to the next round-robin requester.
//     Without the macro, TIMEOUT_CYCLES is ignored and no timeout
//     counter is built.
//
// Ports
//   clock        in   rising-edge clock
//   reset        in   synchronous, active-high
//   request      in   [NUM_CLIENTS]             per-client level request
//   clientData   in   [NUM_CLIENTS*NUM_DIGITS*4] nibbles, client i at i*NUM_DIGITS*4
//   clientPoint  in   [NUM_CLIENTS*NUM_DIGITS]   decimal points, client i at i*NUM_DIGITS
//   grant        out  [NUM_CLIENTS]             one-hot owner, or zero
//   data         out  [NUM_DIGITS*4]            nibbles to the display controller
//   pointEnable  out  [NUM_DIGITS]              decimal points to the display controller
//   displayValid out                            high while the display has an owner
//
// States
//   IDLE | no owner, outputs blank
//   OWN  | grant held, dwell < MIN_HOLD; the owner cannot be released yet
//   FREE | grant held, dwell >= MIN_HOLD; released when the owner drops its request

module display_arbiter #(
    parameter int NUM_CLIENTS    = 4,
    parameter int NUM_DIGITS     = 8,
    parameter int MIN_HOLD       = 1024,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [NUM_CLIENTS-1:0]            request,
    input  logic [NUM_CLIENTS*NUM_DIGITS*4-1:0] clientData,
    input  logic [NUM_CLIENTS*NUM_DIGITS-1:0] clientPoint,
    output logic [NUM_CLIENTS-1:0]            grant,
    output logic [NUM_DIGITS*4-1:0]           data,
    output logic [NUM_DIGITS-1:0]             pointEnable,
    output logic                              displayValid
);

    localparam int MAXCNT = (MIN_HOLD > TIMEOUT_CYCLES) ? MIN_HOLD : TIMEOUT_CYCLES;
    localparam int CW     = $clog2(MAXCNT + 1);
    localparam int IW     = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam int DW     = NUM_DIGITS * 4;

    typedef enum logic [1:0] {IDLE, OWN, FREE} state_t;

    state_t                   state, stateNext;
    logic [CW-1:0]            dwell, dwellNext;
    logic [IW-1:0]            lastGrant, lastGrantNext;
    logic [IW-1:0]            owner, ownerNext;
    logic [NUM_CLIENTS-1:0]   grantNext;
    logic [DW-1:0]            dataNext;
    logic [NUM_DIGITS-1:0]    pointNext;
    logic                     validNext;

    logic [NUM_CLIENTS-1:0]   candidates;
    logic                     winnerFound;
    logic [IW-1:0]            winner;
    logic                     ownerReq;
    logic                     takeGrant;
    logic                     goIdle;

`ifdef DISPLAY_ARBITER_PREEMPT_EN
    logic [CW-1:0]            held, heldNext;
`endif

    // The current owner is masked out, so the scan can only pick another
    // client. In IDLE grant is zero and every requester is a candidate.
    assign candidates = request & ~grant;
    assign ownerReq   = request[owner];

    // Round-robin scan from lastGrant+1, wrapping modulo NUM_CLIENTS.
    always_comb begin
        winnerFound = 1'b0;
        winner      = lastGrant;
        for (int k = 1; k <= NUM_CLIENTS; k++) begin
            if (!winnerFound && candidates[(int'(lastGrant) + k) % NUM_CLIENTS]) begin
                winnerFound = 1'b1;
                winner      = IW'((int'(lastGrant) + k) % NUM_CLIENTS);
            end
        end
    end

    always_comb begin
        stateNext     = state;
        dwellNext     = dwell;
        lastGrantNext = lastGrant;
        ownerNext     = owner;
        grantNext     = grant;
        dataNext      = data;
        pointNext     = pointEnable;
        validNext     = displayValid;
        takeGrant     = 1'b0;
        goIdle        = 1'b0;
`ifdef DISPLAY_ARBITER_PREEMPT_EN
        heldNext      = held;
`endif

        case (state)
            IDLE: begin
                if (winnerFound) takeGrant = 1'b1;
                else             goIdle    = 1'b1;
            end
            OWN, FREE: begin
                if (state == FREE && !ownerReq) begin
                    // A requester that is high in this same cycle can win.
                    // This gives a handover with no gap cycle.
                    if (winnerFound) takeGrant = 1'b1;
                    else             goIdle    = 1'b1;
                end
`ifdef DISPLAY_ARBITER_PREEMPT_EN
                else if (held >= CW'(TIMEOUT_CYCLES) && winnerFound) begin
                    takeGrant = 1'b1;
                end
`endif
                else begin
                    if (ownerReq) begin
                        dataNext  = clientData[int'(owner)*DW +: DW];
                        pointNext = clientPoint[int'(owner)*NUM_DIGITS +: NUM_DIGITS];
                    end
                    if (state == OWN) begin
                        dwellNext = dwell + CW'(1);
                        if (dwell + CW'(1) >= CW'(MIN_HOLD)) stateNext = FREE;
                    end
`ifdef DISPLAY_ARBITER_PREEMPT_EN
                    if (held < CW'(TIMEOUT_CYCLES)) heldNext = held + CW'(1);
`endif
                end
            end
            default: goIdle = 1'b1;
        endcase

        if (takeGrant) begin
            // With MIN_HOLD=1, dwell=1 already meets the hold time.
            stateNext     = (MIN_HOLD <= 1) ? FREE : OWN;
            dwellNext     = CW'(1);
            ownerNext     = winner;
            lastGrantNext = winner;
            grantNext     = NUM_CLIENTS'(1) << winner;
            dataNext      = clientData[int'(winner)*DW +: DW];
            pointNext     = clientPoint[int'(winner)*NUM_DIGITS +: NUM_DIGITS];
            validNext     = 1'b1;
`ifdef DISPLAY_ARBITER_PREEMPT_EN
            heldNext      = CW'(1);
`endif
        end else if (goIdle) begin
            stateNext = IDLE;
            dwellNext = '0;
            grantNext = '0;
            dataNext  = '0;
            pointNext = '0;
            validNext = 1'b0;
`ifdef DISPLAY_ARBITER_PREEMPT_EN
            heldNext  = '0;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            dwell        <= '0;
            lastGrant    <= IW'(NUM_CLIENTS - 1);
            owner        <= '0;
            grant        <= '0;
            data         <= '0;
            pointEnable  <= '0;
            displayValid <= 1'b0;
`ifdef DISPLAY_ARBITER_PREEMPT_EN
            held         <= '0;
`endif
        end else begin
            state        <= stateNext;
            dwell        <= dwellNext;
            lastGrant    <= lastGrantNext;
            owner        <= ownerNext;
            grant        <= grantNext;
            data         <= dataNext;
            pointEnable  <= pointNext;
            displayValid <= validNext;
`ifdef DISPLAY_ARBITER_PREEMPT_EN
            held         <= heldNext;
`endif
        end
    end

endmodule

// File: tb/tb_display_arbiter.sv
// tb_display_arbiter
//   Self-checking bench for display_arbiter. It uses NUM_CLIENTS=4,
//   NUM_DIGITS=8, MIN_HOLD=4 and TIMEOUT_CYCLES=16.
//   A reference model tracks the owner, the hold time and the last grant
//   as plain integers. The bench compares the model against every DUT
//   output on each falling edge.
//   The bench also runs the directed scenarios, and then a randomized
//   request/reset phase.

module tb_display_arbiter;

    localparam int NC  = 4;
    localparam int ND  = 8;
    localparam int MH  = 4;
    localparam int TO  = 16;
    localparam int DW  = ND * 4;

    logic              clock = 1'b0;
    logic              reset;
    logic [NC-1:0]     request;
    logic [NC*DW-1:0]  clientData;
    logic [NC*ND-1:0]  clientPoint;
    logic [NC-1:0]     grant;
    logic [DW-1:0]     data;
    logic [ND-1:0]     pointEnable;
    logic              displayValid;

    int tests  = 0;
    int failed = 0;
    bit started = 1'b0;

    display_arbiter #(
        .NUM_CLIENTS(NC), .NUM_DIGITS(ND), .MIN_HOLD(MH), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock(clock), .reset(reset), .request(request),
        .clientData(clientData), .clientPoint(clientPoint),
        .grant(grant), .data(data), .pointEnable(pointEnable),
        .displayValid(displayValid)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model. mOwner = -1 means the display has no owner.
    int            mOwner = -1;
    int            mHold  = 0;
    int            mLast  = NC - 1;
    int            mTime  = 0;
    logic [DW-1:0] mData  = '0;
    logic [ND-1:0] mPe    = '0;

    function automatic int next_rr(input logic [NC-1:0] req, input int last);
        for (int k = 1; k <= NC; k++)
            if (req[(last + k) % NC]) return (last + k) % NC;
        return -1;
    endfunction

    function automatic logic [NC-1:0] exp_grant();
        return (mOwner < 0) ? '0 : NC'(1) << mOwner;
    endfunction

    task automatic model_take(input int w);
        mOwner = w;
        mLast  = w;
        mHold  = 1;
        mTime  = 1;
        mData  = clientData[w*DW +: DW];
        mPe    = clientPoint[w*ND +: ND];
    endtask

    always @(posedge clock) begin
        logic [NC-1:0] others;
        int w;
        if (reset) begin
            mOwner = -1; mHold = 0; mLast = NC - 1; mTime = 0; mData = '0; mPe = '0;
        end else if (mOwner < 0) begin
            w = next_rr(request, mLast);
            if (w >= 0) model_take(w);
        end else begin
            others = request & ~(NC'(1) << mOwner);
            w = next_rr(others, mLast);
            if (!request[mOwner] && mHold >= MH) begin
                if (w >= 0) model_take(w);
                else begin
                    mOwner = -1; mHold = 0; mTime = 0; mData = '0; mPe = '0;
                end
            end
`ifdef DISPLAY_ARBITER_PREEMPT_EN
            else if (mTime >= TO && w >= 0) model_take(w);
`endif
            else begin
                if (request[mOwner]) begin
                    mData = clientData[mOwner*DW +: DW];
                    mPe   = clientPoint[mOwner*ND +: ND];
                end
                if (mHold < MH) mHold++;
                if (mTime < TO) mTime++;
            end
        end
    end

    always @(negedge clock) begin
        if (started) begin
            check_val("grant", grant, exp_grant());
            check_val("displayValid", displayValid, mOwner >= 0);
            check_val("data", data, mData);
            check_val("pointEnable", pointEnable, mPe);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
        clientData  = {$urandom, $urandom, $urandom, $urandom};
        clientPoint = $urandom;
    endtask

    initial begin
        reset = 1'b1;
        request = '0;
        clientData  = {$urandom, $urandom, $urandom, $urandom};
        clientPoint = $urandom;
        step();
        started = 1'b1;
        step();
        check_val("reset_grant", grant, '0);
        check_val("reset_valid", displayValid, 1'b0);
        reset = 1'b0;

        // Client 0 wins first. It then drops its request while client 2 waits.
        request = 4'b0101;
        step();
        check_val("first_grant", grant, 4'b0001);
        check_val("first_valid", displayValid, 1'b1);
        step();
        request = 4'b0100;
        step();
        step();
        check_val("held_to_min", grant, 4'b0001);
        step();
        check_val("handover", grant, 4'b0100);
        request = '0;
        repeat (8) step();
        check_val("back_idle", displayValid, 1'b0);

        // All clients request. Each owner releases once its hold time is met.
        for (int c = 0; c < 30; c++) begin
            request = 4'b1111;
            if (mOwner >= 0 && mHold >= MH) request[mOwner] = 1'b0;
            step();
        end
        request = '0;
        repeat (8) step();

        // Client 1 requests alone, then releases.
        request = 4'b0010;
        repeat (8) step();
        request = '0;
        repeat (6) step();
        check_val("single_idle_grant", grant, '0);
        check_val("single_idle_data", data, '0);

        // A reset pulse while client 3 owns the display.
        request = 4'b1000;
        repeat (3) step();
        check_val("c3_owns", grant, 4'b1000);
        reset = 1'b1;
        step();
        check_val("rst_abort_grant", grant, '0);
        check_val("rst_abort_data", data, '0);
        reset = 1'b0;
        step();
        check_val("after_rst_grant", grant, 4'b1000);

        // Client 0 holds while client 1 waits (timeout behaviour).
        reset = 1'b1;
        request = '0;
        step();
        reset = 1'b0;
        request = 4'b0011;
        step();
        check_val("hold_start", grant, 4'b0001);
        repeat (15) step();
        check_val("hold_pre_timeout", grant, 4'b0001);
        step();
`ifdef DISPLAY_ARBITER_PREEMPT_EN
        check_val("timeout", grant, 4'b0010);
`else
        check_val("timeout", grant, 4'b0001);
`endif
        repeat (10) step();
        request = '0;
        repeat (10) step();

        // Randomized phase: sticky request bits and rare reset pulses.
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < NC; b++)
                if ($urandom_range(0, 11) == 0) request[b] = ~request[b];
            reset = ($urandom_range(0, 499) == 0);
            step();
        end
        reset = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
